// File: rtl/axilite_regbank_pkg.sv
// Shared definitions for the AXI4-Lite register bank: word map, CONTROL bit
// positions and the request/ack channel state encoding.
package axilite_regbank_pkg;

    // Word addresses of the register map
    localparam int unsigned REG_VERSION    = 0;
    localparam int unsigned REG_SCRATCH    = 1;
    localparam int unsigned REG_CONTROL    = 2;
    localparam int unsigned REG_IRQ_STATUS = 3;
    localparam int unsigned REG_IRQ_ENABLE = 4;
    localparam int unsigned REG_COUNTER    = 5;
    localparam int unsigned REG_STATUS     = 6;
    localparam int unsigned REG_USER_BASE  = 8;

    // CONTROL register bit indices
    localparam int unsigned CTRL_ENABLE_BIT = 0;
    localparam int unsigned CTRL_CLEAR_BIT  = 1;

    // Per-channel request tracking state
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ACK  = 2'd2
    } chan_state_t;

endpackage

// File: rtl/axilite_regbank_if.sv
// Request/acknowledge bus between the AXI4-Lite bridge (master) and the
// register bank (slave). Word-addressed, one strobe per transaction.
interface axilite_regbank_if #(
    parameter int ADDR_WIDTH = 14
);
    logic                  axi_wreq;
    logic [ADDR_WIDTH-1:0] axi_waddr;
    logic [31:0]           axi_wdata;
    logic                  axi_wack;
    logic                  axi_werr;
    logic                  axi_rreq;
    logic [ADDR_WIDTH-1:0] axi_raddr;
    logic [31:0]           axi_rdata;
    logic                  axi_rack;
    logic                  axi_rerr;

    modport master (
        output axi_wreq, axi_waddr, axi_wdata, axi_rreq, axi_raddr,
        input  axi_wack, axi_werr, axi_rdata, axi_rack, axi_rerr
    );

    modport slave (
        input  axi_wreq, axi_waddr, axi_wdata, axi_rreq, axi_raddr,
        output axi_wack, axi_werr, axi_rdata, axi_rack, axi_rerr
    );
endinterface

// File: rtl/axilite_req_delay.sv
// Fixed-latency request tracker: a req pulse accepted in IDLE produces a
// single-cycle ack exactly ACK_LATENCY cycles later. Requests arriving while
// busy are dropped. 'fire' marks the edge that raises ack, so the parent can
// commit writes and sample read data on that same edge.
module axilite_req_delay
    import axilite_regbank_pkg::*;
#(
    parameter int ACK_LATENCY = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic req,
    output logic accept,
    output logic fire,
    output logic busy,
    output logic ack
);

    chan_state_t state_reg;
    logic [2:0]  cnt_reg;
    logic        ack_reg;

    assign busy   = (state_reg != IDLE);
    assign accept = req && (state_reg == IDLE);
    assign fire   = (ACK_LATENCY == 1) ? accept
                                       : ((state_reg == BUSY) && (cnt_reg == 3'd0));
    assign ack    = ack_reg;

    // Channel FSM: count down the remaining latency, then emit one ack cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= 3'd0;
            ack_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    ack_reg <= 1'b0;
                    if (req) begin
                        if (ACK_LATENCY == 1) begin
                            state_reg <= ACK;
                            ack_reg   <= 1'b1;
                        end else begin
                            state_reg <= BUSY;
                            cnt_reg   <= 3'(ACK_LATENCY - 2);
                        end
                    end
                end
                BUSY: begin
                    if (cnt_reg == 3'd0) begin
                        state_reg <= ACK;
                        ack_reg   <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg - 3'd1;
                    end
                end
                ACK: begin
                    state_reg <= IDLE;
                    ack_reg   <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                    ack_reg   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/axilite_regbank.sv
// Control/status register bank behind the AXI4-Lite bridge.
// Optional interrupt block enabled by defining REGBANK_IRQ_EN; without it the
// IRQ_STATUS/IRQ_ENABLE words decode as unmapped and irq_out is tied low.
module axilite_regbank
    import axilite_regbank_pkg::*;
#(
    parameter int          ADDR_WIDTH  = 14,
    parameter int          ACK_LATENCY = 2,
    parameter logic [31:0] VERSION     = 32'h0001_0000,
    parameter int          NUM_USER    = 4
) (
    input  logic                    axi_clk,
    input  logic                    axi_rst,
    axilite_regbank_if.slave        bus,
    input  logic [31:0]             status_in,
    input  logic [7:0]              irq_in,
    output logic                    ctrl_enable,
    output logic [32*NUM_USER-1:0]  user_regs,
    output logic                    irq_out
);

    logic w_accept, w_fire, w_ack, unused_w_busy;
    logic r_accept, r_fire, r_ack, unused_r_busy;

    logic [ADDR_WIDTH-1:0] waddr_reg;
    logic [31:0]           wdata_reg;
    logic [ADDR_WIDTH-1:0] raddr_reg;

    logic        werr_reg, rack_err_reg;
    logic [31:0] rdata_reg;
    logic [31:0] scratch_reg;
    logic        ctrl_enable_reg;
    logic [31:0] counter_reg;

    logic                w_sel_scratch, w_sel_control, w_sel_irq_status, w_sel_irq_enable;
    logic [NUM_USER-1:0] w_sel_user;
    logic                w_writable;
    logic [7:0]          irq_status_rd, irq_enable_rd;

    logic [31:0] rd_value;
    logic        rd_mapped;

    axilite_req_delay #(.ACK_LATENCY(ACK_LATENCY)) u_wr_delay (
        .clk(axi_clk), .rst(axi_rst), .req(bus.axi_wreq),
        .accept(w_accept), .fire(w_fire), .busy(unused_w_busy), .ack(w_ack)
    );

    axilite_req_delay #(.ACK_LATENCY(ACK_LATENCY)) u_rd_delay (
        .clk(axi_clk), .rst(axi_rst), .req(bus.axi_rreq),
        .accept(r_accept), .fire(r_fire), .busy(unused_r_busy), .ack(r_ack)
    );

    // Capture address/data of accepted requests for use at commit time
    always_ff @(posedge axi_clk or posedge axi_rst) begin
        if (axi_rst) begin
            waddr_reg <= '0;
            wdata_reg <= '0;
            raddr_reg <= '0;
        end else begin
            if (w_accept) begin
                waddr_reg <= bus.axi_waddr;
                wdata_reg <= bus.axi_wdata;
            end
            if (r_accept) begin
                raddr_reg <= bus.axi_raddr;
            end
        end
    end

    assign w_sel_scratch = (waddr_reg == ADDR_WIDTH'(REG_SCRATCH));
    assign w_sel_control = (waddr_reg == ADDR_WIDTH'(REG_CONTROL));
    assign w_writable    = w_sel_scratch | w_sel_control | w_sel_irq_status
                         | w_sel_irq_enable | (|w_sel_user);

    // User registers, one flop bank per slot, exported on the flat bus
    generate
        for (genvar gi = 0; gi < NUM_USER; gi++) begin : g_user
            logic [31:0] user_reg;
            assign w_sel_user[gi] = (waddr_reg == ADDR_WIDTH'(REG_USER_BASE + gi));
            assign user_regs[gi*32 +: 32] = user_reg;

            // Update on the commit edge of a write to this slot
            always_ff @(posedge axi_clk or posedge axi_rst) begin
                if (axi_rst)
                    user_reg <= '0;
                else if (w_fire && w_sel_user[gi])
                    user_reg <= wdata_reg;
            end
        end
    endgenerate

    // SCRATCH, CONTROL and the free-running COUNTER; soft-clear beats increment
    always_ff @(posedge axi_clk or posedge axi_rst) begin
        if (axi_rst) begin
            scratch_reg     <= '0;
            ctrl_enable_reg <= 1'b0;
            counter_reg     <= '0;
        end else begin
            if (w_fire && w_sel_scratch)
                scratch_reg <= wdata_reg;
            if (w_fire && w_sel_control)
                ctrl_enable_reg <= wdata_reg[CTRL_ENABLE_BIT];
            if (w_fire && w_sel_control && wdata_reg[CTRL_CLEAR_BIT])
                counter_reg <= '0;
            else if (ctrl_enable_reg)
                counter_reg <= counter_reg + 32'd1;
        end
    end

    assign ctrl_enable = ctrl_enable_reg;

`ifdef REGBANK_IRQ_EN
    localparam bit IRQ_PRESENT = 1'b1;
    logic [7:0] irq_status_reg, irq_enable_reg;
    logic       irq_out_reg;

    assign w_sel_irq_status = (waddr_reg == ADDR_WIDTH'(REG_IRQ_STATUS));
    assign w_sel_irq_enable = (waddr_reg == ADDR_WIDTH'(REG_IRQ_ENABLE));
    assign irq_status_rd    = irq_status_reg;
    assign irq_enable_rd    = irq_enable_reg;
    assign irq_out          = irq_out_reg;

    // Interrupt latch (W1C, new events win over clears) and registered irq_out
    always_ff @(posedge axi_clk or posedge axi_rst) begin
        if (axi_rst) begin
            irq_status_reg <= '0;
            irq_enable_reg <= '0;
            irq_out_reg    <= 1'b0;
        end else begin
            irq_status_reg <= (irq_status_reg
                               & ~((w_fire && w_sel_irq_status) ? wdata_reg[7:0] : 8'h00))
                              | irq_in;
            if (w_fire && w_sel_irq_enable)
                irq_enable_reg <= wdata_reg[7:0];
            irq_out_reg <= |(irq_status_reg & irq_enable_reg);
        end
    end
`else
    localparam bit IRQ_PRESENT = 1'b0;
    logic unused_irq;

    assign w_sel_irq_status = 1'b0;
    assign w_sel_irq_enable = 1'b0;
    assign irq_status_rd    = 8'h00;
    assign irq_enable_rd    = 8'h00;
    assign irq_out          = 1'b0;
    assign unused_irq       = ^irq_in;
`endif

    // Read decode of the captured address; unmapped words return 0
    always_comb begin
        rd_value  = '0;
        rd_mapped = 1'b0;
        if (raddr_reg == ADDR_WIDTH'(REG_VERSION)) begin
            rd_value = VERSION;            rd_mapped = 1'b1;
        end
        if (raddr_reg == ADDR_WIDTH'(REG_SCRATCH)) begin
            rd_value = scratch_reg;        rd_mapped = 1'b1;
        end
        if (raddr_reg == ADDR_WIDTH'(REG_CONTROL)) begin
            rd_value = {31'd0, ctrl_enable_reg}; rd_mapped = 1'b1;
        end
        if (IRQ_PRESENT && (raddr_reg == ADDR_WIDTH'(REG_IRQ_STATUS))) begin
            rd_value = {24'd0, irq_status_rd}; rd_mapped = 1'b1;
        end
        if (IRQ_PRESENT && (raddr_reg == ADDR_WIDTH'(REG_IRQ_ENABLE))) begin
            rd_value = {24'd0, irq_enable_rd}; rd_mapped = 1'b1;
        end
        if (raddr_reg == ADDR_WIDTH'(REG_COUNTER)) begin
            rd_value = counter_reg;        rd_mapped = 1'b1;
        end
        if (raddr_reg == ADDR_WIDTH'(REG_STATUS)) begin
            rd_value = status_in;          rd_mapped = 1'b1;
        end
        for (int i = 0; i < NUM_USER; i++) begin
            if (raddr_reg == ADDR_WIDTH'(REG_USER_BASE + i)) begin
                rd_value  = user_regs[i*32 +: 32];
                rd_mapped = 1'b1;
            end
        end
    end

    // Response flops: data/error are only non-zero in the ack cycle
    always_ff @(posedge axi_clk or posedge axi_rst) begin
        if (axi_rst) begin
            rdata_reg    <= '0;
            rack_err_reg <= 1'b0;
            werr_reg     <= 1'b0;
        end else begin
            rdata_reg    <= r_fire ? rd_value : 32'd0;
            rack_err_reg <= r_fire && !rd_mapped;
            werr_reg     <= w_fire && !w_writable;
        end
    end

    assign bus.axi_wack  = w_ack;
    assign bus.axi_werr  = werr_reg;
    assign bus.axi_rack  = r_ack;
    assign bus.axi_rdata = rdata_reg;
    assign bus.axi_rerr  = rack_err_reg;

endmodule

// File: tb/tb_axilite_regbank.sv
// Directed testbench for axilite_regbank (default ACK_LATENCY=2, NUM_USER=4).
// Covers the IRQ block in whichever build REGBANK_IRQ_EN selects.
module tb_axilite_regbank;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  status_in;
    logic [7:0]   irq_in;
    logic         ctrl_enable;
    logic [127:0] user_regs;
    logic         irq_out;

    int n_cmp = 0;
    int n_err = 0;

    axilite_regbank_if #(.ADDR_WIDTH(14)) bus ();

    axilite_regbank #(
        .ADDR_WIDTH(14), .ACK_LATENCY(2), .VERSION(32'h0001_0000), .NUM_USER(4)
    ) dut (
        .axi_clk(clk), .axi_rst(rst), .bus(bus),
        .status_in(status_in), .irq_in(irq_in),
        .ctrl_enable(ctrl_enable), .user_regs(user_regs), .irq_out(irq_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic [13:0] a, input logic [31:0] d, output logic e);
        int lat;
        @(posedge clk); #1;
        bus.axi_wreq = 1'b1; bus.axi_waddr = a; bus.axi_wdata = d;
        @(posedge clk); #1;
        bus.axi_wreq = 1'b0;
        lat = 1;
        while (bus.axi_wack !== 1'b1 && lat < 12) begin
            @(posedge clk); #1;
            lat++;
        end
        e = bus.axi_werr;
        $display("WR addr=%h data=%h err=%0b lat=%0d", a, d, e, lat);
        check("wr_latency", 32'(lat), 32'd2);
    endtask

    task automatic do_read(input logic [13:0] a, output logic [31:0] d, output logic e);
        int lat;
        @(posedge clk); #1;
        bus.axi_rreq = 1'b1; bus.axi_raddr = a;
        @(posedge clk); #1;
        bus.axi_rreq = 1'b0;
        lat = 1;
        while (bus.axi_rack !== 1'b1 && lat < 12) begin
            @(posedge clk); #1;
            lat++;
        end
        d = bus.axi_rdata;
        e = bus.axi_rerr;
        $display("RD addr=%h data=%h err=%0b lat=%0d", a, d, e, lat);
        check("rd_latency", 32'(lat), 32'd2);
    endtask

    initial begin
        logic [31:0] d, cnt_a, cnt_b, cnt_c;
        logic        e;
        int          acks;

        rst = 1'b1;
        status_in = 32'h0;
        irq_in = 8'h0;
        bus.axi_wreq = 1'b0; bus.axi_waddr = '0; bus.axi_wdata = '0;
        bus.axi_rreq = 1'b0; bus.axi_raddr = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_wack", 32'(bus.axi_wack), 32'd0);
        check("rst_rack", 32'(bus.axi_rack), 32'd0);
        check("rst_rdata", bus.axi_rdata, 32'd0);
        check("rst_ctrl_enable", 32'(ctrl_enable), 32'd0);
        check("rst_user_lo", user_regs[31:0], 32'd0);
        check("rst_irq_out", 32'(irq_out), 32'd0);
        rst = 1'b0;

        // VERSION and SCRATCH after reset
        do_read(14'h0, d, e);
        check("version_data", d, 32'h0001_0000);
        check("version_err", 32'(e), 32'd0);
        do_read(14'h1, d, e);
        check("scratch_reset", d, 32'd0);
        // response bus quiet outside ack cycle
        @(posedge clk); #1;
        check("idle_rdata", bus.axi_rdata, 32'd0);
        check("idle_rack", 32'(bus.axi_rack), 32'd0);

        // SCRATCH write/read, RO write rejected
        do_write(14'h1, 32'hDEAD_BEEF, e);
        check("scratch_werr", 32'(e), 32'd0);
        do_read(14'h1, d, e);
        check("scratch_data", d, 32'hDEAD_BEEF);
        do_write(14'h0, 32'h0000_1234, e);
        check("version_werr", 32'(e), 32'd1);
        do_read(14'h0, d, e);
        check("version_kept", d, 32'h0001_0000);

        // Unmapped accesses
        do_read(14'h7, d, e);
        check("unmapped_rerr", 32'(e), 32'd1);
        check("unmapped_rdata", d, 32'd0);
        do_write(14'h20, 32'h5555_5555, e);
        check("unmapped_werr", 32'(e), 32'd1);
        do_read(14'h1, d, e);
        check("scratch_untouched", d, 32'hDEAD_BEEF);

        // User registers and their upper boundary
        for (int i = 0; i < 4; i++) begin
            do_write(14'(8 + i), 32'hA5A5_0000 | 32'(i), e);
            check("user_werr", 32'(e), 32'd0);
        end
        check("user_bus0", user_regs[31:0], 32'hA5A5_0000);
        check("user_bus3", user_regs[127:96], 32'hA5A5_0003);
        do_read(14'hB, d, e);
        check("user3_read", d, 32'hA5A5_0003);
        do_read(14'hC, d, e);
        check("user_past_end_rerr", 32'(e), 32'd1);
        do_write(14'hC, 32'h1, e);
        check("user_past_end_werr", 32'(e), 32'd1);

        // STATUS reflects status_in
        status_in = 32'hCAFE_0123;
        do_read(14'h6, d, e);
        check("status_read", d, 32'hCAFE_0123);

        // COUNTER: enable, exact increments between reads
        do_write(14'h2, 32'h1, e);
        check("ctrl_enable_on", 32'(ctrl_enable), 32'd1);
        do_read(14'h5, cnt_a, e);
        check("counter_first", cnt_a, 32'd2);
        do_read(14'h5, cnt_b, e);
        check("counter_delta3", cnt_b - cnt_a, 32'd3);
        repeat (100) @(posedge clk);
        do_read(14'h5, cnt_c, e);
        check("counter_delta103", cnt_c - cnt_b, 32'd103);
        do_read(14'h2, d, e);
        check("control_read", d, 32'h1);
        // soft clear also drops enable
        do_write(14'h2, 32'h2, e);
        check("ctrl_enable_off", 32'(ctrl_enable), 32'd0);
        do_read(14'h5, d, e);
        check("counter_cleared", d, 32'd0);
        do_read(14'h2, d, e);
        check("control_clear_reads0", d, 32'd0);

`ifdef REGBANK_IRQ_EN
        do_write(14'h4, 32'h05, e);
        check("irq_en_werr", 32'(e), 32'd0);
        do_read(14'h4, d, e);
        check("irq_en_read", d, 32'h05);
        @(posedge clk); #1; irq_in = 8'h01;
        @(posedge clk); #1; irq_in = 8'h00;
        check("irq_out_not_yet", 32'(irq_out), 32'd0);
        @(posedge clk); #1;
        check("irq_out_set", 32'(irq_out), 32'd1);
        // W1C and a new event on the same edge: event wins
        @(posedge clk); #1;
        bus.axi_wreq = 1'b1; bus.axi_waddr = 14'h3; bus.axi_wdata = 32'h1;
        @(posedge clk); #1;
        bus.axi_wreq = 1'b0; irq_in = 8'h01;
        @(posedge clk); #1;
        irq_in = 8'h00;
        $display("WR addr=0003 data=00000001 concurrent irq_in[0]");
        check("w1c_race_wack", 32'(bus.axi_wack), 32'd1);
        check("w1c_race_werr", 32'(bus.axi_werr), 32'd0);
        do_read(14'h3, d, e);
        check("w1c_race_status", d, 32'h1);
        check("w1c_race_irq_out", 32'(irq_out), 32'd1);
        do_write(14'h3, 32'h1, e);
        do_read(14'h3, d, e);
        check("w1c_cleared", d, 32'h0);
        check("irq_out_cleared", 32'(irq_out), 32'd0);
        // event on a masked source
        @(posedge clk); #1; irq_in = 8'h02;
        @(posedge clk); #1; irq_in = 8'h00;
        @(posedge clk); #1;
        check("irq_masked", 32'(irq_out), 32'd0);
        do_read(14'h3, d, e);
        check("irq_masked_status", d, 32'h2);
`else
        do_write(14'h3, 32'hFF, e);
        check("irq_status_absent_werr", 32'(e), 32'd1);
        do_read(14'h4, d, e);
        check("irq_enable_absent_rerr", 32'(e), 32'd1);
        check("irq_enable_absent_rdata", d, 32'd0);
        @(posedge clk); #1; irq_in = 8'hFF;
        @(posedge clk); #1; irq_in = 8'h00;
        @(posedge clk); #1;
        check("irq_out_tied", 32'(irq_out), 32'd0);
`endif

        // Back-to-back write requests: second is dropped
        @(posedge clk); #1;
        bus.axi_wreq = 1'b1; bus.axi_waddr = 14'h1; bus.axi_wdata = 32'h1111_1111;
        @(posedge clk); #1;
        bus.axi_wdata = 32'h2222_2222;
        @(posedge clk); #1;
        bus.axi_wreq = 1'b0;
        acks = 0;
        for (int k = 0; k < 8; k++) begin
            if (bus.axi_wack === 1'b1) acks++;
            @(posedge clk); #1;
        end
        $display("WR overlap pair acks=%0d", acks);
        check("overlap_ack_count", 32'(acks), 32'd1);
        do_read(14'h1, d, e);
        check("overlap_first_lands", d, 32'h1111_1111);

        // Reset in the middle of a read
        do_write(14'h2, 32'h1, e);
        @(posedge clk); #1;
        bus.axi_rreq = 1'b1; bus.axi_raddr = 14'h1;
        @(posedge clk); #1;
        bus.axi_rreq = 1'b0;
        rst = 1'b1;
        acks = 0;
        for (int k = 0; k < 5; k++) begin
            if (bus.axi_rack === 1'b1) acks++;
            @(posedge clk); #1;
        end
        $display("RD addr=0001 aborted by reset acks=%0d", acks);
        check("reset_no_rack", 32'(acks), 32'd0);
        check("reset_ctrl_enable", 32'(ctrl_enable), 32'd0);
        check("reset_user0", user_regs[31:0], 32'd0);
        check("reset_rdata", bus.axi_rdata, 32'd0);
        rst = 1'b0;
        do_read(14'h1, d, e);
        check("reset_scratch", d, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/axilite_regbank.md
Name: axilite_regbank

Overview:
- Control/status register bank that sits directly downstream of the AXI4-Lite slave bridge.
- Consumes its word-addressed write/read request strobes and returns ack, error and read data within a fixed latency.
- Holds version, scratch, control, interrupt and user registers; exports control/user values to the datapath.

Parameters:
ADDR_WIDTH, 14, word-address width (bridge AXI_ADDRESS_WIDTH minus 2)
ACK_LATENCY, 2, cycles from req to ack; legal 1..8; must stay below the bridge timeout (32)
VERSION, 32'h0001_0000, value returned by the VERSION register
NUM_USER, 4, number of general-purpose RW user registers (1..8)

Ports:
axi_clk  in  1  clock
axi_rst  in  1  asynchronous reset, active-high
axi_wreq  in  1  single-cycle write request pulse
axi_waddr  in  ADDR_WIDTH  word address of write
axi_wdata  in  32  write data
axi_wack  out  1  single-cycle write acknowledge
axi_werr  out  1  write error, valid only with axi_wack
axi_rreq  in  1  single-cycle read request pulse
axi_raddr  in  ADDR_WIDTH  word address of read
axi_rdata  out  32  read data, valid only with axi_rack
axi_rack  out  1  single-cycle read acknowledge
axi_rerr  out  1  read error, valid only with axi_rack
status_in  in  32  datapath status, sampled on read
irq_in  in  8  interrupt event pulses, one per source
ctrl_enable  out  1  CONTROL[0]
user_regs  out  32*NUM_USER  flat user register bus, reg 0 in LSBs
irq_out  out  1  registered OR of (IRQ_STATUS & IRQ_ENABLE)

Behaviour:
- Reset (axi_rst high, async): all outputs 0; SCRATCH, CONTROL, IRQ_STATUS, IRQ_ENABLE, COUNTER and user regs cleared; any in-flight request is discarded with no ack.
- Word map:
  - 0x0 VERSION, RO
  - 0x1 SCRATCH, RW
  - 0x2 CONTROL, RW: bit0 enable; bit1 soft-clear, self-clearing, always reads 0
  - 0x3 IRQ_STATUS, W1C
  - 0x4 IRQ_ENABLE, RW, bits[7:0]
  - 0x5 COUNTER, RO
  - 0x6 STATUS, RO = status_in
  - 0x8..0x8+NUM_USER-1 user, RW
  - all other addresses are unmapped.
- Write path:
  - The request is captured at the axi_wreq cycle (address, data).
  - axi_wack pulses exactly ACK_LATENCY cycles later.
  - The register update takes effect on the same edge that raises axi_wack.
  - Write to a RO or unmapped address: no state change, axi_werr=1 with the ack.
- Read path:
  - The address is captured at the axi_rreq cycle.
  - axi_rack pulses ACK_LATENCY cycles later.
  - axi_rdata/axi_rerr are valid in the ack cycle and 0 otherwise.
  - Unmapped read: rdata=0, rerr=1.
  - The read value is sampled in the ack cycle, so it reflects state before any write committing on that same edge.
- One outstanding request per channel. A wreq/rreq arriving while that channel is busy is dropped (no ack). Read and write channels run independently and may ack in the same cycle.
- Ack latency is implemented as a per-channel busy flag plus a 3-bit down-counter (states IDLE -> BUSY -> ACK -> IDLE).
- COUNTER:
  - increments by 1 each cycle while CONTROL[0]=1; wraps 0xFFFF_FFFF -> 0
  - clears on a CONTROL[1] write (the clear takes priority over the increment that cycle).
- IRQ_STATUS:
  - bit n set on irq_in[n]=1; cleared by writing 1.
  - A set and a clear in the same cycle on the same bit: set wins.
  - Bits [31:8] read 0.
- irq_out: registered, one cycle after the status/enable change.
- ctrl_enable and user_regs are driven directly from their flops.

Optional Feature:
REGBANK_IRQ_EN
- Defined: IRQ_STATUS and IRQ_ENABLE exist as above; irq_out is live.
- Undefined:
  - Addresses 0x3 and 0x4 decode as unmapped (err on read and write).
  - irq_in is ignored; irq_out is tied 0; no IRQ flops are instantiated.

Decomposition:
- Package axilite_regbank_pkg holds:
  - word-address localparams (REG_VERSION..REG_USER_BASE)
  - CONTROL bit indices
  - the req/ack channel state enum (IDLE, BUSY, ACK).
- Sub-module axilite_req_delay, instantiated twice (write and read): a req pulse in produces an ack pulse out after ACK_LATENCY cycles, with a busy output that drops overlapping requests.

Test Plan:
- Reset release, then read 0x0 -> rack 2 cycles after rreq, rdata=0x0001_0000, rerr=0. Read 0x1 -> 0.
- Write 0x1=0xDEAD_BEEF, then read 0x1 -> wack after 2 cycles with werr=0; read returns 0xDEAD_BEEF. Write 0x0=0x1234 -> werr=1; VERSION unchanged.
- Read 0x7 and write 0x20 -> rerr=1 with rdata=0; werr=1; no register changes.
- Write CONTROL=1, wait 100 cycles, read COUNTER -> value ~100 and monotonic. Write CONTROL=2 -> COUNTER reads 0 and ctrl_enable=0.
- With REGBANK_IRQ_EN: write IRQ_ENABLE=0x05; pulse irq_in=0x01 -> irq_out=1 one cycle later. Write IRQ_STATUS=0x01 in the same cycle as irq_in[0]=1 -> bit stays set. Next W1C clears it -> irq_out=0.
- Second wreq issued 1 cycle after the first -> only one wack, only the first write lands. Assert axi_rst mid-read -> no rack; all outputs 0.
